// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, FSM states
// and the mux-select codes it drives into the datapath.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_FETCH   = 4'd1,
        ST_DECODE  = 4'd2,
        ST_MEMADR  = 4'd3,
        ST_MEMRD   = 4'd4,
        ST_MEMWB   = 4'd5,
        ST_MEMWR   = 4'd6,
        ST_EXEC    = 4'd7,
        ST_RWB     = 4'd8,
        ST_BEQ     = 4'd9,
        ST_BNE     = 4'd10,
        ST_JUMP    = 4'd11,
        ST_ADDI_EX = 4'd12,
        ST_ADDI_WB = 4'd13,
        ST_TRAP    = 4'd14,
        ST_UNUSED  = 4'd15
    } state_t;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Last cycle of an instruction; leaving one of these retires it.
    function automatic logic is_retire(input state_t s);
        return (s == ST_MEMWB) || (s == ST_MEMWR) || (s == ST_RWB) ||
               (s == ST_BEQ)   || (s == ST_BNE)   || (s == ST_JUMP) ||
               (s == ST_ADDI_WB);
    endfunction

endpackage

// File: rtl/instr_counter.sv
// Wrapping retired-instruction counter with increment enable.
module instr_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (en)
            count <= count + 1'b1;
    end

endmodule

// File: rtl/multicycle_control.sv
// Moore FSM sequencing a multi-cycle MIPS datapath; traps illegal opcodes
// and counts retired instructions for the debug display.
module multicycle_control
    import mips_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             i_Clk,
    input  logic             i_Rst_n,
    input  logic             i_Run,
    input  logic [5:0]       i_Opcode,
    output logic             o_PCWrite,
    output logic             o_PCWriteCond,
    output logic             o_PCWriteCondNe,
    output logic             o_IorD,
    output logic             o_MemRead,
    output logic             o_MemWrite,
    output logic             o_IRWrite,
    output logic             o_MemtoReg,
    output logic             o_RegDst,
    output logic             o_RegWrite,
    output logic             o_ALUSrcA,
    output logic [1:0]       o_ALUSrcB,
    output logic [1:0]       o_ALUOp,
    output logic [1:0]       o_PCSource,
    output logic [3:0]       o_State,
    output logic             o_Illegal,
    output logic [CNT_W-1:0] o_InstrCount
);

    state_t state;
    state_t next_state;
    logic   is_store;
    logic   retire;

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n)
            state <= ST_IDLE;
        else
            state <= next_state;
    end

    // The opcode is only guaranteed during DECODE, so remember lw vs sw for MEMADR.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n)
            is_store <= 1'b0;
        else if (state == ST_DECODE)
            is_store <= (i_Opcode == OP_SW);
    end

    assign retire = is_retire(state);

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:    next_state = i_Run ? ST_FETCH : ST_IDLE;
            ST_FETCH:   next_state = ST_DECODE;
            ST_DECODE: begin
                case (i_Opcode)
                    OP_RTYPE:     next_state = ST_EXEC;
                    OP_LW, OP_SW: next_state = ST_MEMADR;
                    OP_BEQ:       next_state = ST_BEQ;
                    OP_BNE:       next_state = ST_BNE;
                    OP_J:         next_state = ST_JUMP;
                    OP_ADDI:      next_state = ST_ADDI_EX;
                    default:      next_state = ST_TRAP;
                endcase
            end
            ST_MEMADR:  next_state = is_store ? ST_MEMWR : ST_MEMRD;
            ST_MEMRD:   next_state = ST_MEMWB;
            ST_EXEC:    next_state = ST_RWB;
            ST_ADDI_EX: next_state = ST_ADDI_WB;
            ST_MEMWB, ST_MEMWR, ST_RWB, ST_BEQ, ST_BNE, ST_JUMP, ST_ADDI_WB:
                        next_state = i_Run ? ST_FETCH : ST_IDLE;
            ST_TRAP:    next_state = ST_TRAP;
            default:    next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        o_PCWrite       = 1'b0;
        o_PCWriteCond   = 1'b0;
        o_PCWriteCondNe = 1'b0;
        o_IorD          = 1'b0;
        o_MemRead       = 1'b0;
        o_MemWrite      = 1'b0;
        o_IRWrite       = 1'b0;
        o_MemtoReg      = 1'b0;
        o_RegDst        = 1'b0;
        o_RegWrite      = 1'b0;
        o_ALUSrcA       = 1'b0;
        o_ALUSrcB       = SRCB_RT;
        o_ALUOp         = ALUOP_ADD;
        o_PCSource      = PCSRC_ALU;
        o_Illegal       = 1'b0;
        case (state)
            ST_FETCH: begin
                o_MemRead = 1'b1;
                o_IRWrite = 1'b1;
                o_PCWrite = 1'b1;
                o_ALUSrcB = SRCB_FOUR;
            end
            ST_DECODE:  o_ALUSrcB = SRCB_IMM_SH;
            ST_MEMADR, ST_ADDI_EX: begin
                o_ALUSrcA = 1'b1;
                o_ALUSrcB = SRCB_IMM;
            end
            ST_MEMRD: begin
                o_MemRead = 1'b1;
                o_IorD    = 1'b1;
            end
            ST_MEMWB: begin
                o_RegWrite = 1'b1;
                o_MemtoReg = 1'b1;
            end
            ST_MEMWR: begin
                o_MemWrite = 1'b1;
                o_IorD     = 1'b1;
            end
            ST_EXEC: begin
                o_ALUSrcA = 1'b1;
                o_ALUOp   = ALUOP_FUNCT;
            end
            ST_RWB: begin
                o_RegWrite = 1'b1;
                o_RegDst   = 1'b1;
            end
            ST_BEQ: begin
                o_ALUSrcA     = 1'b1;
                o_ALUOp       = ALUOP_SUB;
                o_PCWriteCond = 1'b1;
                o_PCSource    = PCSRC_ALUOUT;
            end
            ST_BNE: begin
                o_ALUSrcA       = 1'b1;
                o_ALUOp         = ALUOP_SUB;
                o_PCWriteCondNe = 1'b1;
                o_PCSource      = PCSRC_ALUOUT;
            end
            ST_JUMP: begin
                o_PCWrite  = 1'b1;
                o_PCSource = PCSRC_JUMP;
            end
            ST_ADDI_WB: o_RegWrite = 1'b1;
            ST_TRAP:    o_Illegal  = 1'b1;
            default: ;
        endcase
    end

    assign o_State = state;

    instr_counter #(.CNT_W(CNT_W)) u_instr_counter (
        .clk   (i_Clk),
        .rst_n (i_Rst_n),
        .en    (retire),
        .count (o_InstrCount)
    );

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: instruction table plus hand-written
// sequences for run gating, trap and asynchronous reset.
module tb_multicycle_control;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             run = 1'b0;
    logic [5:0]       opcode = 6'b0;
    logic             pc_write, pc_write_cond, pc_write_cond_ne, iord;
    logic             mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write;
    logic             alu_src_a, illegal;
    logic [1:0]       alu_src_b, alu_op, pc_source;
    logic [3:0]       state;
    logic [CNT_W-1:0] instr_count;

    int errors = 0;
    int checks = 0;
    int cnt    = 0;

    typedef struct {
        logic [3:0] st;
        int         cnt;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [5:0] op;
        int         len;
        logic [3:0] path[4];
    } vec_t;

    logic [17:0] ctrl_tab[16];
    logic [17:0] ctrl_act;

    multicycle_control #(.CNT_W(CNT_W)) dut (
        .i_Clk           (clk),
        .i_Rst_n         (rst_n),
        .i_Run           (run),
        .i_Opcode        (opcode),
        .o_PCWrite       (pc_write),
        .o_PCWriteCond   (pc_write_cond),
        .o_PCWriteCondNe (pc_write_cond_ne),
        .o_IorD          (iord),
        .o_MemRead       (mem_read),
        .o_MemWrite      (mem_write),
        .o_IRWrite       (ir_write),
        .o_MemtoReg      (mem_to_reg),
        .o_RegDst        (reg_dst),
        .o_RegWrite      (reg_write),
        .o_ALUSrcA       (alu_src_a),
        .o_ALUSrcB       (alu_src_b),
        .o_ALUOp         (alu_op),
        .o_PCSource      (pc_source),
        .o_State         (state),
        .o_Illegal       (illegal),
        .o_InstrCount    (instr_count)
    );

    always #5 clk = ~clk;

    assign ctrl_act = {pc_write, pc_write_cond, pc_write_cond_ne, iord, mem_read, mem_write,
                       ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
                       alu_op, pc_source, illegal};

    function automatic logic [17:0] cw(input logic pcw, pcc, pcne, io, mr, mw, irw, m2r,
                                       rd, rw, sa, input logic [1:0] sb_, op, pcs,
                                       input logic ill);
        return {pcw, pcc, pcne, io, mr, mw, irw, m2r, rd, rw, sa, sb_, op, pcs, ill};
    endfunction

    task automatic check(input string name, input logic [3:0] st, input int c);
        checks++;
        if (state !== st) begin
            errors++;
            $display("FAIL %s state: got %0d want %0d", name, state, st);
        end
        checks++;
        if (ctrl_act !== ctrl_tab[st]) begin
            errors++;
            $display("FAIL %s ctrl (state %0d): got %b want %b", name, st, ctrl_act, ctrl_tab[st]);
        end
        checks++;
        if (instr_count !== CNT_W'(c)) begin
            errors++;
            $display("FAIL %s count: got %0d want %0d", name, instr_count, CNT_W'(c));
        end
        checks++;
        if (mem_read && mem_write) begin
            errors++;
            $display("FAIL %s memexcl: got rd=1 wr=1 want not both", name);
        end
    endtask

    // Expected result is queued when the cycle is launched and popped once the DUT has settled.
    task automatic step(input string name, input logic [3:0] st, input int c);
        exp_t e;
        sb.push_back('{st: st, cnt: c});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check(name, e.st, e.cnt);
    endtask

    vec_t vecs[7];

    initial begin
        ctrl_tab[0]  = '0;
        ctrl_tab[1]  = cw(1,0,0,0,1,0,1,0,0,0,0,2'b01,2'b00,2'b00,0);
        ctrl_tab[2]  = cw(0,0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0);
        ctrl_tab[3]  = cw(0,0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0);
        ctrl_tab[4]  = cw(0,0,0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0);
        ctrl_tab[5]  = cw(0,0,0,0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,0);
        ctrl_tab[6]  = cw(0,0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0);
        ctrl_tab[7]  = cw(0,0,0,0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0);
        ctrl_tab[8]  = cw(0,0,0,0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00,0);
        ctrl_tab[9]  = cw(0,1,0,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,0);
        ctrl_tab[10] = cw(0,0,1,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,0);
        ctrl_tab[11] = cw(1,0,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10,0);
        ctrl_tab[12] = cw(0,0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0);
        ctrl_tab[13] = cw(0,0,0,0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00,0);
        ctrl_tab[14] = cw(0,0,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,1);
        ctrl_tab[15] = '0;

        vecs[0] = '{op: 6'b100011, len: 4, path: '{4'd2, 4'd3, 4'd4, 4'd5}};
        vecs[1] = '{op: 6'b101011, len: 3, path: '{4'd2, 4'd3, 4'd6, 4'd0}};
        vecs[2] = '{op: 6'b000000, len: 3, path: '{4'd2, 4'd7, 4'd8, 4'd0}};
        vecs[3] = '{op: 6'b000100, len: 2, path: '{4'd2, 4'd9, 4'd0, 4'd0}};
        vecs[4] = '{op: 6'b000101, len: 2, path: '{4'd2, 4'd10, 4'd0, 4'd0}};
        vecs[5] = '{op: 6'b000010, len: 2, path: '{4'd2, 4'd11, 4'd0, 4'd0}};
        vecs[6] = '{op: 6'b001000, len: 3, path: '{4'd2, 4'd12, 4'd13, 4'd0}};

        #22 rst_n = 1'b1;
        #1 check("reset", 4'd0, 0);
        step("idle_hold", 4'd0, 0);

        run = 1'b1;
        step("fetch0", 4'd1, cnt);
        for (int i = 0; i < 7; i++) begin
            opcode = vecs[i].op;
            for (int k = 0; k < vecs[i].len; k++)
                step($sformatf("vec%0d_s%0d", i, k), vecs[i].path[k], cnt);
            cnt++;
            step($sformatf("vec%0d_ret", i), 4'd1, cnt);
        end

        opcode = 6'b101011;
        step("sw_dec", 4'd2, cnt);
        step("sw_adr", 4'd3, cnt);
        run = 1'b0;
        step("sw_wr", 4'd6, cnt);
        cnt++;
        for (int k = 0; k < 3; k++)
            step("sw_idle", 4'd0, cnt);

        run = 1'b1;
        step("br_fetch", 4'd1, cnt);
        opcode = 6'b000100;
        step("beq_dec", 4'd2, cnt);
        step("beq", 4'd9, cnt);
        cnt++;
        step("bne_fetch", 4'd1, cnt);
        opcode = 6'b000101;
        step("bne_dec", 4'd2, cnt);
        step("bne", 4'd10, cnt);
        cnt++;
        step("j_fetch", 4'd1, cnt);
        opcode = 6'b000010;
        step("j_dec", 4'd2, cnt);
        step("j", 4'd11, cnt);
        cnt++;
        step("j_ret", 4'd1, cnt);

        opcode = 6'b000000;
        for (int i = 0; i < 16; i++) begin
            step("wrap_dec", 4'd2, cnt);
            step("wrap_exec", 4'd7, cnt);
            step("wrap_rwb", 4'd8, cnt);
            cnt++;
            step("wrap_ret", 4'd1, cnt);
        end

        step("rst_dec", 4'd2, cnt);
        step("rst_exec", 4'd7, cnt);
        #2 rst_n = 1'b0;
        cnt = 0;
        #1 check("async_rst_exec", 4'd0, cnt);
        step("rst_hold0", 4'd0, cnt);
        step("rst_hold1", 4'd0, cnt);
        #3 rst_n = 1'b1;

        step("trap_fetch", 4'd1, cnt);
        opcode = 6'b111111;
        step("trap_dec", 4'd2, cnt);
        for (int k = 0; k < 21; k++)
            step("trap_hold", 4'd14, cnt);
        #2 rst_n = 1'b0;
        #1 check("async_rst_trap", 4'd0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore FSM controller that sequences a multi-cycle MIPS datapath: one shared ALU and one unified memory, reused across the cycles of each instruction.
- Replaces the single-cycle combinational decoder.
- Drives PC, IR, register-file, memory and ALU mux enables from its state register.
- Gates execution with a run input, traps illegal opcodes, and counts retired instructions for the seven-segment debug display.

Parameters:
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- i_Clk  in  1  system clock, rising edge.
- i_Rst_n  in  1  asynchronous active-low reset.
- i_Run  in  1  level; allows a new instruction fetch.
- i_Opcode  in  6  IR[31:26]; valid from the DECODE cycle onward.
- o_PCWrite  out  1  unconditional PC load.
- o_PCWriteCond  out  1  PC load if ALU zero (beq).
- o_PCWriteCondNe  out  1  PC load if ALU not zero (bne).
- o_IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- o_MemRead  out  1  memory read strobe.
- o_MemWrite  out  1  memory write strobe.
- o_IRWrite  out  1  instruction register load.
- o_MemtoReg  out  1  writeback select: 1 = MDR.
- o_RegDst  out  1  destination register select: 1 = rd, 0 = rt.
- o_RegWrite  out  1  register file write.
- o_ALUSrcA  out  1  ALU A select: 0 = PC, 1 = rs.
- o_ALUSrcB  out  2  ALU B select: 00 = rt, 01 = const 4, 10 = sign-extended imm, 11 = sign-extended imm << 2.
- o_ALUOp  out  2  00 = add, 01 = sub, 10 = funct-decoded.
- o_PCSource  out  2  PC source: 00 = ALU, 01 = ALUOut, 10 = jump target.
- o_State  out  4  current state encoding, for debug.
- o_Illegal  out  1  sticky trap flag.
- o_InstrCount  out  CNT_W  retired-instruction count.

Behaviour:
- State encodings: IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC=7, RWB=8, BEQ=9, BNE=10, JUMP=11, ADDI_EX=12, ADDI_WB=13, TRAP=14. Code 15 is unreachable and recovers to IDLE.
- Reset, asynchronous, any state: state goes to IDLE, o_InstrCount=0, all control outputs 0. Reset mid-instruction aborts with no further strobes.
- IDLE: go to FETCH if i_Run=1, else stay.
- FETCH: go to DECODE.
- DECODE: branch on i_Opcode, sampled this cycle only.
  - 000000 → EXEC
  - 100011 (lw) or 101011 (sw) → MEMADR
  - 000100 → BEQ
  - 000101 → BNE
  - 000010 → JUMP
  - 001000 → ADDI_EX
  - any other opcode → TRAP
- MEMADR: lw → MEMRD, sw → MEMWR, using the opcode captured in a 1-bit flag at DECODE.
- MEMRD → MEMWB. EXEC → RWB. ADDI_EX → ADDI_WB.
- Retire states: MEMWB, MEMWR, RWB, BEQ, BNE, JUMP, ADDI_WB.
  - o_InstrCount increments by 1 on leaving a retire state, wrapping modulo 2^CNT_W.
  - Next state is FETCH if i_Run=1, else IDLE.
  - i_Run is ignored in every other state, so a started instruction always completes.
- TRAP: absorbing; exits only via reset. o_Illegal=1 only in TRAP. Trapped instructions are not counted.
- Outputs are decoded from the state register only (Moore). Every output not listed for a state is 0.
  - FETCH: MemRead, IRWrite, PCWrite; ALUSrcB=01; IorD, ALUSrcA, ALUOp, PCSource all 0.
  - DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00.
  - MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - MEMRD: MemRead, IorD.
  - MEMWB: RegWrite, MemtoReg, RegDst=0.
  - MEMWR: MemWrite, IorD.
  - EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10.
  - RWB: RegWrite, RegDst=1.
  - BEQ: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond, PCSource=01.
  - BNE: same as BEQ, but PCWriteCondNe replaces PCWriteCond.
  - JUMP: PCWrite, PCSource=10.
  - ADDI_EX: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - ADDI_WB: RegWrite, RegDst=0.
- Latency, FETCH through retire: lw 5 cycles; sw, R-type and addi 4; beq, bne and j 3. IDLE adds 1 cycle when entered.
- o_MemRead and o_MemWrite are never asserted in the same cycle.

Decomposition:
- Shared package mips_pkg holds:
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_ADDI
  - 4-bit state constants
  - ALUOp constants
  - ALUSrcB constants
  - PCSource constants
- One natural sub-module: instr_counter (CNT_W-bit wrapping counter, async active-low reset, increment enable). The FSM and output decode remain in multicycle_control.

Test Plan:
- Reset, then i_Run=1 with opcode 100011 (lw) → o_State sequence 0,1,2,3,4,5,1; MemRead high in states 1 and 4; RegWrite+MemtoReg only in 5; o_InstrCount=1.
- Opcode 101011 (sw), then drop i_Run during MEMADR → instruction completes through 6 (MemWrite=1, IorD=1), then state 0; o_InstrCount=1; stays 0 while i_Run=0.
- Opcodes 000100, 000101, 000010 back to back → states 9, 10, 11 at cycles 3, 6, 9; PCSource=01, 01, 10 respectively; PCWriteCond only in 9, PCWriteCondNe only in 10.
- Opcode 111111 → state 14, o_Illegal=1 held for 20 cycles, counter unchanged; i_Rst_n low → state 0, o_Illegal=0 asynchronously.
- CNT_W=4, 16 consecutive R-type instructions → o_InstrCount wraps 15→0.
- Assert i_Rst_n low mid-EXEC → all outputs 0 immediately, state 0, counter 0, no RegWrite pulse.
